// File: rtl/alarm_controller.sv
// Alarm time register, match-edge detection and the arm/ring/snooze/timeout
// state machine feeding the buzzer and the status LEDs.
module alarm_controller #(
   parameter int HR_BITS     = 5,
   parameter int MIN_BITS    = 6,
   parameter int MAX_HR      = 23,
   parameter int MAX_MIN     = 59,
   parameter int SNOOZE_MIN  = 9,
   parameter int RING_MIN    = 5,
   parameter int MAX_SNOOZES = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [HR_BITS-1:0]  cur_hr,
   input  logic [MIN_BITS-1:0] cur_min,
   input  logic                min_tick,
   input  logic                alarm_en,
   input  logic                set_en,
   input  logic [HR_BITS-1:0]  set_hr,
   input  logic [MIN_BITS-1:0] set_min,
   input  logic                snooze,
   input  logic                stop,
   output logic                ring,
   output logic                snoozing,
   output logic                armed,
   output logic [HR_BITS-1:0]  alarm_hr,
   output logic [MIN_BITS-1:0] alarm_min,
   output logic [1:0]          snooze_left
);

   localparam int RC_W = (RING_MIN > 1) ? $clog2(RING_MIN) : 1;
   localparam int SC_W = (SNOOZE_MIN > 1) ? $clog2(SNOOZE_MIN) : 1;

   typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

   state_t            state;
   logic              match_q;
   logic [RC_W-1:0]   ring_cnt;
   logic [SC_W-1:0]   snz_cnt;

   logic match;
   logic alarm_event;
   logic set_valid;
   logic set_match;

   assign match       = (cur_hr == alarm_hr) && (cur_min == alarm_min);
   assign alarm_event = match && !match_q;
   assign set_valid   = set_en && (set_hr <= HR_BITS'(MAX_HR)) && (set_min <= MIN_BITS'(MAX_MIN));
   assign set_match   = (cur_hr == set_hr) && (cur_min == set_min);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ring        <= 1'b0;
         snoozing    <= 1'b0;
         armed       <= 1'b0;
         alarm_hr    <= '0;
         alarm_min   <= '0;
         snooze_left <= 2'(MAX_SNOOZES);
         match_q     <= 1'b1;
         ring_cnt    <= '0;
         snz_cnt     <= '0;
      end else begin
         // Seeding match_q from the new alarm time keeps a set-to-now from ringing.
         match_q <= set_valid ? set_match : match;
         if (set_valid) begin
            alarm_hr  <= set_hr;
            alarm_min <= set_min;
         end

         if (!alarm_en) begin
            state    <= IDLE;
            ring     <= 1'b0;
            snoozing <= 1'b0;
            armed    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= ARMED;
                  armed <= 1'b1;
               end
               ARMED: begin
                  if (!stop && !set_valid && alarm_event) begin
                     state       <= RINGING;
                     ring        <= 1'b1;
                     ring_cnt    <= '0;
                     snooze_left <= 2'(MAX_SNOOZES);
                  end
               end
               RINGING: begin
                  if (stop) begin
                     state <= ARMED;
                     ring  <= 1'b0;
                  end else if (set_valid) begin
                     state       <= ARMED;
                     ring        <= 1'b0;
                     snooze_left <= 2'(MAX_SNOOZES);
                  end else if (snooze && (snooze_left != 2'd0)) begin
                     state       <= SNOOZE;
                     ring        <= 1'b0;
                     snoozing    <= 1'b1;
                     snz_cnt     <= '0;
                     snooze_left <= snooze_left - 2'd1;
                  end else if (min_tick) begin
                     if (ring_cnt == RC_W'(RING_MIN - 1)) begin
                        state <= ARMED;
                        ring  <= 1'b0;
                     end else begin
                        ring_cnt <= ring_cnt + RC_W'(1);
                     end
                  end
               end
               SNOOZE: begin
                  if (stop) begin
                     state    <= ARMED;
                     snoozing <= 1'b0;
                  end else if (set_valid) begin
                     state       <= ARMED;
                     snoozing    <= 1'b0;
                     snooze_left <= 2'(MAX_SNOOZES);
                  end else if (min_tick) begin
                     if (snz_cnt == SC_W'(SNOOZE_MIN - 1)) begin
                        state    <= RINGING;
                        snoozing <= 1'b0;
                        ring     <= 1'b1;
                        ring_cnt <= '0;
                     end else begin
                        snz_cnt <= snz_cnt + SC_W'(1);
                     end
                  end
               end
               default: begin
                  state    <= IDLE;
                  ring     <= 1'b0;
                  snoozing <= 1'b0;
                  armed    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: set, ring, snooze, timeout, disable, reset.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] cur_hr;
   logic [5:0] cur_min;
   logic       min_tick;
   logic       alarm_en;
   logic       set_en;
   logic [4:0] set_hr;
   logic [5:0] set_min;
   logic       snooze;
   logic       stop;
   logic       ring;
   logic       snoozing;
   logic       armed;
   logic [4:0] alarm_hr;
   logic [5:0] alarm_min;
   logic [1:0] snooze_left;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alarm_controller dut (
      .clk(clk), .rst(rst), .cur_hr(cur_hr), .cur_min(cur_min), .min_tick(min_tick),
      .alarm_en(alarm_en), .set_en(set_en), .set_hr(set_hr), .set_min(set_min),
      .snooze(snooze), .stop(stop), .ring(ring), .snoozing(snoozing), .armed(armed),
      .alarm_hr(alarm_hr), .alarm_min(alarm_min), .snooze_left(snooze_left)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the alarm minute for one cycle and returns, producing a fresh match edge.
   task automatic make_ring(input logic [5:0] away_min, input logic [5:0] at_min);
      cur_min = away_min;
      tick();
      cur_min = at_min;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; alarm_en = 1'b0; set_en = 1'b0; snooze = 1'b0; stop = 1'b0; min_tick = 1'b0;
      cur_hr = 5'd0; cur_min = 6'd0; set_hr = 5'd0; set_min = 6'd0;
      tick(); tick();
      rst = 1'b0;
      vectors++; if (ring !== 1'b0) begin miscompares++; $display("FAIL reset_ring: got %0b expected 0", ring); end
      vectors++; if (armed !== 1'b0) begin miscompares++; $display("FAIL reset_armed: got %0b expected 0", armed); end
      vectors++; if (snoozing !== 1'b0) begin miscompares++; $display("FAIL reset_snoozing: got %0b expected 0", snoozing); end
      vectors++; if (alarm_hr !== 5'd0 || alarm_min !== 6'd0) begin miscompares++; $display("FAIL reset_alarm_time: got %0d:%0d expected 0:0", alarm_hr, alarm_min); end
      vectors++; if (snooze_left !== 2'd3) begin miscompares++; $display("FAIL reset_snooze_left: got %0d expected 3", snooze_left); end
      alarm_en = 1'b1;
      tick();
      vectors++; if (armed !== 1'b1) begin miscompares++; $display("FAIL enable_armed: got %0b expected 1", armed); end
      vectors++; if (ring !== 1'b0) begin miscompares++; $display("FAIL enable_no_ring: got %0b expected 0", ring); end
      $display("test_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   task automatic test_set_ring();
      cur_hr = 5'd7; cur_min = 6'd29;
      tick();
      set_hr = 5'd7; set_min = 6'd30; set_en = 1'b1;
      tick();
      set_en = 1'b0;
      vectors++; if (alarm_hr !== 5'd7 || alarm_min !== 6'd30) begin miscompares++; $display("FAIL set_load: got %0d:%0d expected 7:30", alarm_hr, alarm_min); end
      tick();
      vectors++; if (ring !== 1'b0) begin miscompares++; $display("FAIL ring_before_match: got %0b expected 0", ring); end
      cur_min = 6'd30;
      tick();
      vectors++; if (ring !== 1'b1) begin miscompares++; $display("FAIL ring_on_event: got %0b expected 1", ring); end
      vectors++; if (snooze_left !== 2'd3) begin miscompares++; $display("FAIL event_snooze_left: got %0d expected 3", snooze_left); end
      stop = 1'b1; tick(); stop = 1'b0;
      vectors++; if (ring !== 1'b0 || armed !== 1'b1) begin miscompares++; $display("FAIL stop: got ring=%0b armed=%0b expected ring=0 armed=1", ring, armed); end
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++; if (ring !== 1'b0) begin miscompares++; $display("FAIL hold_no_rering cycle %0d: got %0b expected 0", i, ring); end
      end
      $display("test_set_ring done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   task automatic test_snooze();
      make_ring(6'd31, 6'd30);
      vectors++; if (ring !== 1'b1) begin miscompares++; $display("FAIL snooze_setup_ring: got %0b expected 1", ring); end
      for (int s = 0; s < 3; s++) begin
         snooze = 1'b1; tick(); snooze = 1'b0;
         vectors++; if (snoozing !== 1'b1 || ring !== 1'b0 || armed !== 1'b1) begin miscompares++; $display("FAIL snooze_enter %0d: got snoozing=%0b ring=%0b armed=%0b expected 1 0 1", s, snoozing, ring, armed); end
         vectors++; if (snooze_left !== 2'(2 - s)) begin miscompares++; $display("FAIL snooze_left %0d: got %0d expected %0d", s, snooze_left, 2 - s); end
         for (int k = 1; k <= 9; k++) begin
            min_tick = 1'b1; tick(); min_tick = 1'b0; tick();
            if (k == 8) begin
               vectors++; if (snoozing !== 1'b1 || ring !== 1'b0) begin miscompares++; $display("FAIL snooze_tick8 %0d: got snoozing=%0b ring=%0b expected 1 0", s, snoozing, ring); end
            end
         end
         vectors++; if (ring !== 1'b1 || snoozing !== 1'b0) begin miscompares++; $display("FAIL snooze_expire %0d: got ring=%0b snoozing=%0b expected 1 0", s, ring, snoozing); end
      end
      snooze = 1'b1; tick(); snooze = 1'b0;
      vectors++; if (ring !== 1'b1 || snoozing !== 1'b0) begin miscompares++; $display("FAIL snooze_exhausted: got ring=%0b snoozing=%0b expected 1 0", ring, snoozing); end
      vectors++; if (snooze_left !== 2'd0) begin miscompares++; $display("FAIL snooze_left_zero: got %0d expected 0", snooze_left); end
      stop = 1'b1; tick(); stop = 1'b0;
      vectors++; if (ring !== 1'b0 || armed !== 1'b1) begin miscompares++; $display("FAIL snooze_final_stop: got ring=%0b armed=%0b expected 0 1", ring, armed); end
      $display("test_snooze done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   task automatic test_timeout();
      make_ring(6'd31, 6'd30);
      vectors++; if (snooze_left !== 2'd3) begin miscompares++; $display("FAIL rering_snooze_left: got %0d expected 3", snooze_left); end
      for (int k = 1; k <= 5; k++) begin
         min_tick = 1'b1; tick(); min_tick = 1'b0;
         if (k == 4) begin
            vectors++; if (ring !== 1'b1) begin miscompares++; $display("FAIL timeout_tick4: got %0b expected 1", ring); end
         end
      end
      vectors++; if (ring !== 1'b0 || armed !== 1'b1) begin miscompares++; $display("FAIL timeout: got ring=%0b armed=%0b expected 0 1", ring, armed); end
      make_ring(6'd31, 6'd30);
      for (int k = 0; k < 4; k++) begin min_tick = 1'b1; tick(); min_tick = 1'b0; end
      min_tick = 1'b1; stop = 1'b1; tick(); min_tick = 1'b0; stop = 1'b0;
      vectors++; if (ring !== 1'b0 || armed !== 1'b1 || snoozing !== 1'b0) begin miscompares++; $display("FAIL tick_and_stop: got ring=%0b armed=%0b snoozing=%0b expected 0 1 0", ring, armed, snoozing); end
      make_ring(6'd31, 6'd30);
      snooze = 1'b1; stop = 1'b1; tick(); snooze = 1'b0; stop = 1'b0;
      vectors++; if (ring !== 1'b0 || snoozing !== 1'b0 || armed !== 1'b1) begin miscompares++; $display("FAIL snooze_and_stop: got ring=%0b snoozing=%0b armed=%0b expected 0 0 1", ring, snoozing, armed); end
      vectors++; if (snooze_left !== 2'd3) begin miscompares++; $display("FAIL snooze_and_stop_left: got %0d expected 3", snooze_left); end
      $display("test_timeout done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   task automatic test_set_boundaries();
      cur_hr = 5'd12; cur_min = 6'd5;
      tick();
      set_hr = 5'd12; set_min = 6'd5; set_en = 1'b1; tick(); set_en = 1'b0;
      vectors++; if (alarm_hr !== 5'd12 || alarm_min !== 6'd5) begin miscompares++; $display("FAIL set_now_load: got %0d:%0d expected 12:5", alarm_hr, alarm_min); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (ring !== 1'b0) begin miscompares++; $display("FAIL set_now_no_ring cycle %0d: got %0b expected 0", i, ring); end
      end
      set_hr = 5'd24; set_min = 6'd10; set_en = 1'b1; tick(); set_en = 1'b0;
      vectors++; if (alarm_hr !== 5'd12 || alarm_min !== 6'd5) begin miscompares++; $display("FAIL set_bad_hour: got %0d:%0d expected 12:5", alarm_hr, alarm_min); end
      set_hr = 5'd7; set_min = 6'd60; set_en = 1'b1; tick(); set_en = 1'b0;
      vectors++; if (alarm_hr !== 5'd12 || alarm_min !== 6'd5) begin miscompares++; $display("FAIL set_bad_minute: got %0d:%0d expected 12:5", alarm_hr, alarm_min); end
      $display("test_set_boundaries done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   task automatic test_midnight_disable();
      cur_hr = 5'd23; cur_min = 6'd59;
      tick();
      set_hr = 5'd0; set_min = 6'd0; set_en = 1'b1; tick(); set_en = 1'b0;
      tick();
      vectors++; if (ring !== 1'b0) begin miscompares++; $display("FAIL midnight_pre: got %0b expected 0", ring); end
      cur_hr = 5'd0; cur_min = 6'd0;
      tick();
      vectors++; if (ring !== 1'b1) begin miscompares++; $display("FAIL midnight_ring: got %0b expected 1", ring); end
      snooze = 1'b1; tick(); snooze = 1'b0;
      vectors++; if (snoozing !== 1'b1) begin miscompares++; $display("FAIL midnight_snooze: got %0b expected 1", snoozing); end
      alarm_en = 1'b0; tick();
      vectors++; if (snoozing !== 1'b0 || armed !== 1'b0 || ring !== 1'b0) begin miscompares++; $display("FAIL disable: got snoozing=%0b armed=%0b ring=%0b expected 0 0 0", snoozing, armed, ring); end
      alarm_en = 1'b1; tick();
      vectors++; if (armed !== 1'b1 || ring !== 1'b0) begin miscompares++; $display("FAIL reenable: got armed=%0b ring=%0b expected 1 0", armed, ring); end
      $display("test_midnight_disable done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   task automatic test_reset_ringing();
      make_ring(6'd1, 6'd0);
      vectors++; if (ring !== 1'b1) begin miscompares++; $display("FAIL rst_setup_ring: got %0b expected 1", ring); end
      rst = 1'b1; tick();
      vectors++; if (ring !== 1'b0 || armed !== 1'b0 || snoozing !== 1'b0) begin miscompares++; $display("FAIL rst_outputs: got ring=%0b armed=%0b snoozing=%0b expected 0 0 0", ring, armed, snoozing); end
      vectors++; if (alarm_hr !== 5'd0 || alarm_min !== 6'd0 || snooze_left !== 2'd3) begin miscompares++; $display("FAIL rst_regs: got %0d:%0d left=%0d expected 0:0 left=3", alarm_hr, alarm_min, snooze_left); end
      rst = 1'b0; tick();
      vectors++; if (armed !== 1'b1 || ring !== 1'b0) begin miscompares++; $display("FAIL post_rst_arm: got armed=%0b ring=%0b expected 1 0", armed, ring); end
      $display("test_reset_ringing done: vectors=%0d miscompares=%0d", vectors, miscompares);
   endtask

   initial begin
      test_reset();
      test_set_ring();
      test_snooze();
      test_timeout();
      test_set_boundaries();
      test_midnight_disable();
      test_reset_ringing();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
